aes_128_inv_key_sched: RTL and testbench

- Reverse AES-128 key-schedule engine. Given the final (round-10) key, it walks the schedule backwards and emits round keys 10, 9, …, 0 in the order the decryption datapath consumes them.
- It is the counterpart of the forward key-expansion pipeline on the encrypt side.
- It is iterative, not unrolled: one byte-substitution unit, reused every round.
- It sits between the key-load logic and the future iterative inverse-round datapath, which pulls keys through a valid/ready handshake.

---
 rtl/aes_128_inv_key_sched_if.sv | 56 +++++
 rtl/aes_128_inv_key_sched.sv | 230 +++++++++++++++++++++++
 tb/tb_aes_128_inv_key_sched.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_128_inv_key_sched_if.sv
//-----------------------------------------------------------------------------
// aes_128_inv_key_sched_if
//
// Purpose: bundles the control and round-key handshake signals of the reverse
// AES-128 key-schedule engine.
//
// Signals:
//   start     load key_in and begin a sequence (ignored while busy)
//   key_in    128-bit round-10 key, word0 = [127:96] ... word3 = [31:0]
//   busy      sequence in progress
//   rk_valid  rk_out / rk_round / rk_last hold a valid key
//   rk_ready  consumer accepts the key when rk_valid & rk_ready
//   rk_out    current round key
//   rk_round  round index of rk_out, 10 down to 0
//   rk_last   high with rk_valid when rk_round = 0
//   done      one-cycle pulse after the round-0 handshake
//
// Modports:
//   slave   the key-schedule engine
//   master  the key-load logic / inverse-round datapath driving it
//-----------------------------------------------------------------------------
interface aes_128_inv_key_sched_if;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_last;
    logic         done;

    modport slave (
        input  start,
        input  key_in,
        input  rk_ready,
        output busy,
        output rk_valid,
        output rk_out,
        output rk_round,
        output rk_last,
        output done
    );

    modport master (
        output start,
        output key_in,
        output rk_ready,
        input  busy,
        input  rk_valid,
        input  rk_out,
        input  rk_round,
        input  rk_last,
        input  done
    );
endinterface

// File: rtl/aes_128_inv_key_sched.sv
//-----------------------------------------------------------------------------
// aes_128_inv_key_sched
//
// Purpose: iterative reverse AES-128 key schedule. Starting from the round-10
// key it walks the schedule backwards and presents round keys 10, 9, ..., 0
// through a valid/ready handshake. A single 4-byte S-box unit (registered,
// one cycle latency) is reused every round; each round after the first costs
// three cycles (SUB, COMBINE, PRESENT).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   ks     aes_128_inv_key_sched_if.slave (start/key_in, busy, rk_* handshake,
//          done)
//
// Build option:
//   AES_INV_KEY_MIXCOL_EN  when defined, rounds 9..1 are presented in the
//                          equivalent-inverse-cipher form (InvMixColumns of
//                          each column); rounds 10 and 0 stay raw. The
//                          internal schedule always runs on raw keys.
//-----------------------------------------------------------------------------
module aes_128_inv_key_sched (
    input  logic                          clk,
    input  logic                          rst_n,
    aes_128_inv_key_sched_if.slave        ks
);

    // Forward AES S-box, byte 0x00 in the most significant position.
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESENT,
        S_SUB,
        S_COMBINE
    } state_t;

    // Byte x sits at bit offset (255 - x) * 8, i.e. {~x, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_FLAT[{~x, 3'b000} +: 8];
    endfunction

    // Round constant applied when stepping from round r back to round r-1.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    state_t        state_q;
    logic [127:0]  key_q;       // raw round key currently held / presented
    logic [3:0]    round_q;
    logic [95:0]   w123_q;      // {w1', w2', w3'} of the previous round key
    logic [31:0]   sbox_q;      // registered SubWord(RotWord(w3'))
    logic          busy_q;
    logic          valid_q;
    logic          last_q;
    logic          done_q;

    logic [31:0]   w0, w1, w2, w3;
    logic [31:0]   w1_d, w2_d, w3_d, w0_d;
    logic [31:0]   rot_w3;
    logic [31:0]   sbox_d;
    logic          handshake;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    // Undo the chained XORs of the forward expansion for words 1..3.
    assign w3_d = w3 ^ w2;
    assign w2_d = w2 ^ w1;
    assign w1_d = w1 ^ w0;

    assign rot_w3 = {w3_d[23:0], w3_d[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox_lane
            assign sbox_d[gi*8 +: 8] = sbox(rot_w3[gi*8 +: 8]);
        end
    endgenerate

    // The S-box result is only consumed in COMBINE, one cycle after SUB drove
    // it, so clocking it every cycle is harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbox_q <= 32'h0;
        end else begin
            sbox_q <= sbox_d;
        end
    end

    assign w0_d = w0 ^ sbox_q ^ {rcon(round_q), 24'h0};

    assign handshake = valid_q & ks.rk_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            key_q   <= 128'h0;
            round_q <= 4'd0;
            w123_q  <= 96'h0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ks.start) begin
                        key_q   <= ks.key_in;
                        round_q <= 4'd10;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        state_q <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (handshake) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        if (round_q == 4'd0) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_SUB;
                        end
                    end
                end
                S_SUB: begin
                    w123_q  <= {w1_d, w2_d, w3_d};
                    state_q <= S_COMBINE;
                end
                S_COMBINE: begin
                    key_q   <= {w0_d, w123_q};
                    round_q <= round_q - 4'd1;
                    valid_q <= 1'b1;
                    last_q  <= (round_q == 4'd1);
                    state_q <= S_PRESENT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ks.busy     = busy_q;
    assign ks.rk_valid = valid_q;
    assign ks.rk_round = round_q;
    assign ks.rk_last  = last_q;
    assign ks.done     = done_q;

`ifdef AES_INV_KEY_MIXCOL_EN
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // InvMixColumns of one column, a0 in the most significant byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    logic [127:0] imc_key;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_imc_col
            assign imc_key[127 - 32*gi -: 32] = inv_mix_col(key_q[127 - 32*gi -: 32]);
        end
    endgenerate

    // First and last round keys are used raw by the inverse cipher.
    assign ks.rk_out = ((round_q != 4'd0) && (round_q != 4'd10)) ? imc_key : key_q;
`else
    assign ks.rk_out = key_q;
`endif

endmodule

// File: tb/tb_aes_128_inv_key_sched.sv
module tb_aes_128_inv_key_sched;

`ifdef AES_INV_KEY_MIXCOL_EN
    localparam bit MIXCOL = 1'b1;
`else
    localparam bit MIXCOL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_128_inv_key_sched_if ks();

    aes_128_inv_key_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ks    (ks.slave)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [7:0]   sb [256];
    logic [127:0] ref_rk [11];
    logic [127:0] got_rk [11];

    typedef struct {
        logic [127:0] key;
        int           round;
        logic [127:0] golden;
    } vec_t;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] p;
        a = a_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[x] = s;
        end
    endtask

    function automatic logic [7:0] rcon_tb(input int n);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 1; i < n; i++) r = gmul(r, 8'h02);
        return r;
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] t);
        logic [31:0] r;
        r = {t[23:0], t[31:24]};
        return {sb[r[31:24]], sb[r[23:16]], sb[r[15:8]], sb[r[7:0]]};
    endfunction

    // Run the forward recurrence w[i] = w[i-4] ^ f(w[i-1]) backwards from w[40..43].
    task automatic compute_ref(input logic [127:0] k10);
        logic [31:0] w [44];
        logic [31:0] t;
        w[40] = k10[127:96];
        w[41] = k10[95:64];
        w[42] = k10[63:32];
        w[43] = k10[31:0];
        for (int i = 43; i >= 4; i--) begin
            t = w[i-1];
            if (i % 4 == 0) t = sub_rot(t) ^ {rcon_tb(i / 4), 24'h0};
            w[i-4] = w[i] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] imc(input logic [127:0] k);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = k[127 - 32*c -: 8];
            a1 = k[119 - 32*c -: 8];
            a2 = k[111 - 32*c -: 8];
            a3 = k[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [127:0] exp_of(input logic [127:0] raw, input int r);
        return (MIXCOL && r >= 1 && r <= 9) ? imc(raw) : raw;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Full sequence. mode 0: rk_ready high; mode 1: random backpressure.
    // stall_round: hold rk_ready low 5 cycles at that round.
    // intr_round: pulse start with intr_key in that round's handshake cycle.
    task automatic run_full(input logic [127:0] k, input int mode, input int stall_round,
                            input int intr_round, input logic [127:0] intr_key);
        int hs_cyc;
        int guard;
        int nstall;
        int pres;
        logic [127:0] cap_out;
        logic [3:0]   cap_round;
        compute_ref(k);
        ks.key_in   = k;
        ks.start    = 1'b1;
        ks.rk_ready = (mode == 0);
        cyc = 0;
        step();
        ks.start  = 1'b0;
        ks.key_in = ~k;
        check("busy_after_start", 128'(ks.busy), 128'd1);
        check("done_low_after_start", 128'(ks.done), 128'd0);
        hs_cyc = -2;
        for (int r = 10; r >= 0; r--) begin
            guard = 0;
            while (!ks.rk_valid && guard < 12) begin
                if (mode == 1) ks.rk_ready = 1'($urandom % 2);
                step();
                guard++;
            end
            if (!ks.rk_valid) begin
                tests++;
                fails++;
                $display("FAIL valid_timeout: round %0d not presented, got rk_valid=0 required 1", r);
                return;
            end
            pres = cyc;
            check("rk_round", 128'(ks.rk_round), 128'(r));
            check("rk_out", ks.rk_out, exp_of(ref_rk[r], r));
            check("rk_last", 128'(ks.rk_last), 128'(r == 0));
            check("present_cycle", 128'(pres), 128'(hs_cyc + 3));
            if (mode == 0 && stall_round < 0)
                check("present_cycle_abs", 128'(pres), 128'(1 + 3 * (10 - r)));
            $display("[TB] cycle %0d round %0d rk_out %h", pres, ks.rk_round, ks.rk_out);
            got_rk[r] = ks.rk_out;
            cap_out   = ks.rk_out;
            cap_round = ks.rk_round;
            nstall = (r == stall_round) ? 5 : ((mode == 1) ? int'($urandom_range(0, 3)) : 0);
            ks.rk_ready = 1'b0;
            for (int s = 0; s < nstall; s++) begin
                step();
                check("stall_valid", 128'(ks.rk_valid), 128'd1);
                check("stall_out", ks.rk_out, cap_out);
                check("stall_round", 128'(ks.rk_round), 128'(cap_round));
            end
            ks.rk_ready = 1'b1;
            if (r == intr_round) begin
                ks.start  = 1'b1;
                ks.key_in = intr_key;
            end
            hs_cyc = cyc;
            step();
            ks.start = 1'b0;
            check("valid_after_hs", 128'(ks.rk_valid), 128'd0);
            if (r == 0) begin
                check("done_pulse", 128'(ks.done), 128'd1);
                check("busy_end", 128'(ks.busy), 128'd0);
                check("last_end", 128'(ks.rk_last), 128'd0);
                if (mode == 0 && stall_round < 0)
                    check("done_cycle", 128'(cyc), 128'd32);
            end else begin
                check("busy_mid", 128'(ks.busy), 128'd1);
            end
        end
    endtask

    // ---------------- test ----------------
    localparam logic [127:0] K1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    vec_t vecs [6];
    logic [127:0] last_key;
    int guard;

    initial begin
        vecs[0] = '{K1, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{K1,  9, 128'hac7766f319fadc2128d12941575c006e};
        vecs[2] = '{K1,  0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[3] = '{K2, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
        vecs[4] = '{K2,  9, 128'h549932d1f08557681093ed9cbe2c974e};
        vecs[5] = '{K2,  0, 128'h000102030405060708090a0b0c0d0e0f};

        build_sbox();
        ks.start    = 1'b0;
        ks.key_in   = 128'h0;
        ks.rk_ready = 1'b0;
        rst_n       = 1'b0;
        repeat (3) step();
        check("reset_busy", 128'(ks.busy), 128'd0);
        check("reset_valid", 128'(ks.rk_valid), 128'd0);
        check("reset_last", 128'(ks.rk_last), 128'd0);
        check("reset_done", 128'(ks.done), 128'd0);
        check("reset_out", ks.rk_out, 128'h0);
        check("reset_round", 128'(ks.rk_round), 128'd0);
        rst_n = 1'b1;
        step();

        // Golden vectors; consecutive runs start in the done-pulse cycle.
        last_key = 128'h0;
        for (int v = 0; v < 6; v++) begin
            if (v == 0 || vecs[v].key != last_key) begin
                run_full(vecs[v].key, 0, -1, -1, 128'h0);
                last_key = vecs[v].key;
            end
            check($sformatf("golden_k%0d_r%0d", v, vecs[v].round),
                  got_rk[vecs[v].round], exp_of(vecs[v].golden, vecs[v].round));
        end

        // Backpressure at round 7.
        run_full(K1, 0, 7, -1, 128'h0);
        // Start with a different key while busy at round 5.
        run_full(K1, 0, -1, 5, K2);

        // Reset while round 4 is in SUB.
        ks.key_in   = K2;
        ks.start    = 1'b1;
        ks.rk_ready = 1'b1;
        step();
        ks.start = 1'b0;
        guard = 0;
        while (!(ks.rk_valid && ks.rk_round == 4'd4) && guard < 40) begin
            step();
            guard++;
        end
        check("reach_round4", 128'(ks.rk_valid && ks.rk_round == 4'd4), 128'd1);
        step();
        rst_n = 1'b0;
        #1;
        check("abort_busy", 128'(ks.busy), 128'd0);
        check("abort_valid", 128'(ks.rk_valid), 128'd0);
        check("abort_out", ks.rk_out, 128'h0);
        check("abort_round", 128'(ks.rk_round), 128'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_abort_valid", 128'(ks.rk_valid), 128'd0);
            check("post_abort_busy", 128'(ks.busy), 128'd0);
        end
        run_full(K1, 0, -1, -1, 128'h0);
        check("post_abort_r0", got_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        // Random keys with random backpressure, checked against the model.
        for (int n = 0; n < 4; n++)
            run_full({$urandom, $urandom, $urandom, $urandom}, 1, -1, -1, 128'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got timeout required completion");
        $fatal(1, "timeout");
    end

endmodule
